fm_window_gen: RTL and testbench

Streaming 3x3 window generator that feeds the binarization stage (`rsign`). It accepts one 16-bit pixel per channel per accepted cycle in raster order and buffers two lines per channel. For every pixel position whose full 3x3 neighbourhood is available, it emits one `FM_DEPTH` x `CORE_SIZE` window with a single-cycle `data_out_valid` pulse. Its output bundle matches the `data_in_valid`/`data_in` input of `rsign` exactly.

---
 rtl/fm_window_gen_if.sv | 29 ++
 rtl/fm_window_gen.sv | 131 +++++++++++++
 tb/tb_fm_window_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fm_window_gen_if.sv
// Pixel-stream in / 3x3-window out bundle of fm_window_gen.
// The master side is the pixel source; the slave side is the window generator.
interface fm_window_gen_if #(
   parameter int FM_DEPTH   = 64,
   parameter int CORE_SIZE  = 9,
   parameter int DATA_WIDTH = 16
);
   logic                                               data_in_valid;
   logic [FM_DEPTH-1:0][DATA_WIDTH-1:0]                data_in;
   logic                                               data_out_valid;
   logic [FM_DEPTH-1:0][CORE_SIZE-1:0][DATA_WIDTH-1:0] data_out;
   logic                                               frame_done;

   modport master (
      output data_in_valid,
      output data_in,
      input  data_out_valid,
      input  data_out,
      input  frame_done
   );

   modport slave (
      input  data_in_valid,
      input  data_in,
      output data_out_valid,
      output data_out,
      output frame_done
   );
endinterface

// File: rtl/fm_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a shift window per channel,
// emitting one registered window per pixel whose full neighbourhood is available.
module fm_window_gen #(
   parameter int FM_DEPTH   = 64,
   parameter int CORE_SIZE  = 9,
   parameter int FM_WIDTH   = 32,
   parameter int FM_HEIGHT  = 32,
   parameter int DATA_WIDTH = 16
) (
   input  logic           clk,
   input  logic           rstn,
   fm_window_gen_if.slave bus
);

   localparam int COL_W = (FM_WIDTH  > 1) ? $clog2(FM_WIDTH)  : 1;
   localparam int ROW_W = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1;

   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(FM_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(FM_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_EMIT  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_EMIT  = ROW_W'(2);

   // Window slot j = 3*r + c; r=0 oldest line, c=0 leftmost column.
   localparam int J00 = 0, J01 = 1, J02 = 2;
   localparam int J10 = 3, J11 = 4, J12 = 5;
   localparam int J20 = 6, J21 = 7, J22 = 8;

   typedef logic [DATA_WIDTH-1:0] pix_t;
   typedef pix_t [CORE_SIZE-1:0]  win_t;

   logic [COL_W-1:0] col_r;
   logic [ROW_W-1:0] row_r;
   logic [COL_W-1:0] col_nxt_s;
   logic [ROW_W-1:0] row_nxt_s;

   logic accept_s;
   logic emit_s;
   logic frame_end_s;
   logic col_last_s;
   logic row_last_s;

   pix_t line1_r [FM_DEPTH][FM_WIDTH];
   pix_t line2_r [FM_DEPTH][FM_WIDTH];
   win_t win_r     [FM_DEPTH];
   win_t win_nxt_s [FM_DEPTH];

   logic                                               data_out_valid_r;
   logic                                               frame_done_r;
   logic [FM_DEPTH-1:0][CORE_SIZE-1:0][DATA_WIDTH-1:0] data_out_r;

   // Raster position bookkeeping and emission decision for the current cycle.
   always_comb begin
      accept_s    = bus.data_in_valid;
      col_last_s  = (col_r == COL_LAST);
      row_last_s  = (row_r == ROW_LAST);
      emit_s      = 1'b0;
      frame_end_s = 1'b0;
      col_nxt_s   = col_r;
      row_nxt_s   = row_r;
      if (accept_s) begin
         emit_s      = (row_r >= ROW_EMIT) && (col_r >= COL_EMIT);
         frame_end_s = col_last_s && row_last_s;
         if (col_last_s) begin
            col_nxt_s = {COL_W{1'b0}};
            if (row_last_s) begin
               row_nxt_s = {ROW_W{1'b0}};
            end else begin
               row_nxt_s = row_r + ROW_W'(1);
            end
         end else begin
            col_nxt_s = col_r + COL_W'(1);
            row_nxt_s = row_r;
         end
      end else begin
         emit_s      = 1'b0;
         frame_end_s = 1'b0;
      end
   end

   // Next window: shift columns left, new right column comes from the line buffers and input.
   always_comb begin
      for (int ch = 0; ch < FM_DEPTH; ch++) begin
         win_nxt_s[ch][J00] = win_r[ch][J01];
         win_nxt_s[ch][J01] = win_r[ch][J02];
         win_nxt_s[ch][J02] = line2_r[ch][col_r];
         win_nxt_s[ch][J10] = win_r[ch][J11];
         win_nxt_s[ch][J11] = win_r[ch][J12];
         win_nxt_s[ch][J12] = line1_r[ch][col_r];
         win_nxt_s[ch][J20] = win_r[ch][J21];
         win_nxt_s[ch][J21] = win_r[ch][J22];
         win_nxt_s[ch][J22] = bus.data_in[ch];
      end
   end

   // Pixel storage; contents are always overwritten before they can reach the output.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         for (int ch = 0; ch < FM_DEPTH; ch++) begin
            win_r[ch]          <= win_nxt_s[ch];
            line2_r[ch][col_r] <= line1_r[ch][col_r];
            line1_r[ch][col_r] <= bus.data_in[ch];
         end
      end
   end

   // Position counters and registered outputs; data_out holds between windows.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col_r            <= {COL_W{1'b0}};
         row_r            <= {ROW_W{1'b0}};
         data_out_valid_r <= 1'b0;
         frame_done_r     <= 1'b0;
         data_out_r       <= {(FM_DEPTH*CORE_SIZE*DATA_WIDTH){1'b0}};
      end else begin
         col_r            <= col_nxt_s;
         row_r            <= row_nxt_s;
         data_out_valid_r <= emit_s;
         frame_done_r     <= frame_end_s;
         if (emit_s) begin
            for (int ch = 0; ch < FM_DEPTH; ch++) begin
               data_out_r[ch] <= win_nxt_s[ch];
            end
         end
      end
   end

   assign bus.data_out_valid = data_out_valid_r;
   assign bus.frame_done     = frame_done_r;
   assign bus.data_out       = data_out_r;

endmodule

// File: tb/tb_fm_window_gen.sv
// Directed bench for fm_window_gen on a 2-channel 4x4 frame; expected windows are
// derived from the pixel formula ch*256 + row*16 + col (+ frame offset).
module tb_fm_window_gen;
   localparam int FM_DEPTH   = 2;
   localparam int CORE_SIZE  = 9;
   localparam int FM_WIDTH   = 4;
   localparam int FM_HEIGHT  = 4;
   localparam int DATA_WIDTH = 16;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   fm_window_gen_if #(.FM_DEPTH(FM_DEPTH), .CORE_SIZE(CORE_SIZE), .DATA_WIDTH(DATA_WIDTH)) bus ();

   fm_window_gen #(
      .FM_DEPTH(FM_DEPTH), .CORE_SIZE(CORE_SIZE), .FM_WIDTH(FM_WIDTH),
      .FM_HEIGHT(FM_HEIGHT), .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulses = 0;
   int n_done   = 0;
   logic [15:0] exp_win [FM_DEPTH][CORE_SIZE];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pix(input int base, input int ch, input int r, input int c);
      return base + ch*256 + r*16 + c;
   endfunction

   task automatic check_win(input string tag);
      for (int ch = 0; ch < FM_DEPTH; ch++)
         for (int j = 0; j < CORE_SIZE; j++)
            check_eq(tag, 32'(bus.data_out[ch][j]), 32'(exp_win[ch][j]));
   endtask

   task automatic clear_exp();
      for (int ch = 0; ch < FM_DEPTH; ch++)
         for (int j = 0; j < CORE_SIZE; j++)
            exp_win[ch][j] = 16'h0000;
   endtask

   task automatic send_pixel(input int r, input int c, input int base, input int gap);
      logic emit;
      @(negedge clk);
      bus.data_in_valid = 1'b1;
      for (int ch = 0; ch < FM_DEPTH; ch++) bus.data_in[ch] = 16'(pix(base, ch, r, c));
      @(posedge clk);
      #1;
      emit = (r >= 2) && (c >= 2);
      if (emit) begin
         for (int ch = 0; ch < FM_DEPTH; ch++)
            for (int j = 0; j < CORE_SIZE; j++)
               exp_win[ch][j] = 16'(pix(base, ch, r - 2 + j/3, c - 2 + j%3));
      end
      if (bus.data_out_valid === 1'b1) n_pulses++;
      if (bus.frame_done === 1'b1) n_done++;
      check_eq("valid", 32'(bus.data_out_valid), 32'(emit));
      check_eq("frame_done", 32'(bus.frame_done), 32'((r == FM_HEIGHT-1) && (c == FM_WIDTH-1)));
      check_win(emit ? "window" : "hold");
      if (gap > 0) begin
         @(negedge clk);
         bus.data_in_valid = 1'b0;
         for (int ch = 0; ch < FM_DEPTH; ch++) bus.data_in[ch] = 16'($urandom);
         repeat (gap) begin
            @(posedge clk);
            #1;
            check_eq("gap_valid", 32'(bus.data_out_valid), 32'd0);
            check_eq("gap_frame_done", 32'(bus.frame_done), 32'd0);
            check_win("gap_hold");
         end
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.data_in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         check_eq("idle_valid", 32'(bus.data_out_valid), 32'd0);
         check_win("idle_hold");
      end
   endtask

   task automatic send_frame(input int base, input int max_gap);
      for (int r = 0; r < FM_HEIGHT; r++)
         for (int c = 0; c < FM_WIDTH; c++)
            send_pixel(r, c, base, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
   endtask

   initial begin
      rstn = 1'b0;
      bus.data_in_valid = 1'b0;
      bus.data_in = '0;
      clear_exp();

      // Reset held with the strobe toggling: nothing may come out.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.data_in_valid = ~bus.data_in_valid;
         for (int ch = 0; ch < FM_DEPTH; ch++) bus.data_in[ch] = 16'($urandom);
         @(posedge clk);
         #1;
         check_eq("rst_valid", 32'(bus.data_out_valid), 32'd0);
         check_eq("rst_frame_done", 32'(bus.frame_done), 32'd0);
         check_win("rst_data");
      end
      @(negedge clk);
      bus.data_in_valid = 1'b0;
      rstn = 1'b1;

      // Continuous frame with hand-computed spot values.
      n_pulses = 0; n_done = 0;
      for (int r = 0; r < FM_HEIGHT; r++) begin
         for (int c = 0; c < FM_WIDTH; c++) begin
            send_pixel(r, c, 0, 0);
            if (r == 2 && c == 2) begin
               check_eq("s2_ch1_j0", 32'(bus.data_out[1][0]), 32'h100);
               check_eq("s2_ch1_j2", 32'(bus.data_out[1][2]), 32'h102);
               check_eq("s2_ch1_j4", 32'(bus.data_out[1][4]), 32'h111);
               check_eq("s2_ch1_j8", 32'(bus.data_out[1][8]), 32'h122);
            end
            if (r == 3 && c == 3) begin
               check_eq("s2_last_ch0_j0", 32'(bus.data_out[0][0]), 32'h11);
               check_eq("s2_last_ch0_j8", 32'(bus.data_out[0][8]), 32'h33);
               check_eq("s2_last_done", 32'(bus.frame_done), 32'd1);
            end
         end
      end
      idle(3);
      check_eq("s2_pulses", 32'(n_pulses), 32'd4);
      check_eq("s2_done", 32'(n_done), 32'd1);

      // Gapped frame: same windows, outputs hold through idle cycles.
      n_pulses = 0; n_done = 0;
      send_frame(0, 3);
      idle(2);
      check_eq("s3_pulses", 32'(n_pulses), 32'd4);
      check_eq("s3_done", 32'(n_done), 32'd1);

      // Two frames back to back, second offset by 0x40.
      n_pulses = 0; n_done = 0;
      send_frame(0, 0);
      for (int r = 0; r < FM_HEIGHT; r++) begin
         for (int c = 0; c < FM_WIDTH; c++) begin
            send_pixel(r, c, 32'h40, 0);
            if (r == 2 && c == 2) begin
               check_eq("s4_f2_ch0_j0", 32'(bus.data_out[0][0]), 32'h40);
               check_eq("s4_f2_ch0_j8", 32'(bus.data_out[0][8]), 32'h62);
            end
         end
      end
      idle(2);
      check_eq("s4_pulses", 32'(n_pulses), 32'd8);
      check_eq("s4_done", 32'(n_done), 32'd2);

      // Reset after pixel (2,1), then a full restart.
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < FM_WIDTH; c++)
            send_pixel(r, c, 0, 0);
      send_pixel(2, 0, 0, 0);
      send_pixel(2, 1, 0, 0);
      @(negedge clk);
      bus.data_in_valid = 1'b0;
      rstn = 1'b0;
      #1;
      clear_exp();
      check_eq("s5_async_valid", 32'(bus.data_out_valid), 32'd0);
      check_win("s5_async_data");
      @(posedge clk);
      #1;
      check_win("s5_rst_hold");
      @(negedge clk);
      rstn = 1'b1;
      n_pulses = 0; n_done = 0;
      send_frame(0, 0);
      idle(2);
      check_eq("s5_pulses", 32'(n_pulses), 32'd4);
      check_eq("s5_done", 32'(n_done), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
